// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU control path.
// Covers state encodings, opcode defaults, mux/ALU codes and the control-word layout.
package mcpu_pkg;

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_EXECUTE = 5'd6,
        S_ALUWB   = 5'd7,
        S_ADDIEX  = 5'd8,
        S_ADDIWB  = 5'd9,
        S_BRANCH  = 5'd10,
        S_JAL     = 5'd11,
        S_TRAP    = 5'd12
    } state_t;

    localparam logic [3:0] OPC_ADD  = 4'b0000;
    localparam logic [3:0] OPC_NAND = 4'b0010;
    localparam logic [3:0] OPC_LW   = 4'b1010;
    localparam logic [3:0] OPC_SW   = 4'b1001;
    localparam logic [3:0] OPC_BEQ  = 4'b1011;
    localparam logic [3:0] OPC_JAL  = 4'b1101;
    localparam logic [3:0] OPC_ADDI = 4'b1111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

    localparam logic [1:0] ASB_REG  = 2'b00;
    localparam logic [1:0] ASB_FOUR = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;
    localparam logic [1:0] ASB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Field order fixes the bit positions of the packed control word.
    typedef struct packed {
        logic       mem_req;
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       branch;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       link;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mcpu_ctrl_rom.sv
// Combinational state -> control-word table for the multicycle controller.
// Only FETCH looks at mem_ready, so PC/IR never update during a fetch wait state.
module mcpu_ctrl_rom
    import mcpu_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field defaults to zero first so no path through the case infers a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ASB_FOUR;
                ctrl.pcwrite = mem_ready;
                ctrl.irwrite = mem_ready;
            end
            S_DECODE: ctrl.alusrcb = ASB_BOFF;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ASB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.aluop   = ALUOP_SUB;
            end
            S_JAL: begin
                ctrl.regwrite = 1'b1;
                ctrl.link     = 1'b1;
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsrc    = PCSRC_JUMP;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_TRAP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle CPU: sequences states from the opcode,
// stalls on the memory handshake and counts retired instructions.
module multicycle_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int               OP_W    = 4,
    parameter int               CNT_W   = 32,
    parameter int               TRAP_EN = 1,
    parameter logic [OP_W-1:0]  OP_ADD  = OP_W'(OPC_ADD),
    parameter logic [OP_W-1:0]  OP_NAND = OP_W'(OPC_NAND),
    parameter logic [OP_W-1:0]  OP_LW   = OP_W'(OPC_LW),
    parameter logic [OP_W-1:0]  OP_SW   = OP_W'(OPC_SW),
    parameter logic [OP_W-1:0]  OP_BEQ  = OP_W'(OPC_BEQ),
    parameter logic [OP_W-1:0]  OP_JAL  = OP_W'(OPC_JAL),
    parameter logic [OP_W-1:0]  OP_ADDI = OP_W'(OPC_ADDI)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pcwrite,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             branch,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             link,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [4:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t state_q;
    state_t state_d;
    logic   retire;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)         state_d = S_MEMADR;
                else if (op == OP_ADD || op == OP_NAND) state_d = S_EXECUTE;
                else if (op == OP_BEQ)                  state_d = S_BRANCH;
                else if (op == OP_JAL)                  state_d = S_JAL;
                else if (op == OP_ADDI)                 state_d = S_ADDIEX;
                else state_d = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
                retire  = mem_ready;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // A trap returns to FETCH without counting as a retired instruction.
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JAL: retire = 1'b1;
            default:   state_d = S_FETCH;
        endcase
    end

    mcpu_ctrl_rom u_rom (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign state    = state_q;
    assign mem_req  = ctrl.mem_req;
    assign pcwrite  = ctrl.pcwrite;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign branch   = ctrl.branch;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign link     = ctrl.link;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: two controller instances (trap enabled / 32-bit counter, trap disabled / 4-bit counter)
// run random instruction streams against an instruction-level expected-trace model.
module tb_multicycle_ctrl_fsm;
    import mcpu_pkg::*;

    typedef struct packed {
        logic [4:0] st;
        logic       mreq, pcw, memw, irw, regw, asa, br, iord, m2r, rdst, lnk, ill;
        logic [1:0] asb, pcs, aop;
    } exp_t;

    typedef struct {
        state_t s;
        logic   rdy;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] op_a, op_b;
    logic       rdy_a, rdy_b;

    logic        mem_req_a, pcwrite_a, memwrite_a, irwrite_a, regwrite_a, alusrca_a, branch_a;
    logic        iord_a, memtoreg_a, regdst_a, link_a, illegal_a;
    logic [1:0]  alusrcb_a, pcsrc_a, aluop_a;
    logic [4:0]  state_a;
    logic [31:0] retired_a;

    logic        mem_req_b, pcwrite_b, memwrite_b, irwrite_b, regwrite_b, alusrca_b, branch_b;
    logic        iord_b, memtoreg_b, regdst_b, link_b, illegal_b;
    logic [1:0]  alusrcb_b, pcsrc_b, aluop_b;
    logic [4:0]  state_b;
    logic [3:0]  retired_b;

    exp_t obs_a, obs_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] cnt_a = '0;
    logic [3:0]  cnt_b = '0;

    multicycle_ctrl_fsm #(.OP_W(4), .CNT_W(32), .TRAP_EN(1)) dut_a (
        .clk(clk), .reset(reset), .op(op_a), .mem_ready(rdy_a),
        .mem_req(mem_req_a), .pcwrite(pcwrite_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
        .regwrite(regwrite_a), .alusrca(alusrca_a), .branch(branch_a), .iord(iord_a),
        .memtoreg(memtoreg_a), .regdst(regdst_a), .link(link_a), .alusrcb(alusrcb_a),
        .pcsrc(pcsrc_a), .aluop(aluop_a), .illegal(illegal_a), .state(state_a), .retired(retired_a)
    );

    multicycle_ctrl_fsm #(.OP_W(4), .CNT_W(4), .TRAP_EN(0)) dut_b (
        .clk(clk), .reset(reset), .op(op_b), .mem_ready(rdy_b),
        .mem_req(mem_req_b), .pcwrite(pcwrite_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
        .regwrite(regwrite_b), .alusrca(alusrca_b), .branch(branch_b), .iord(iord_b),
        .memtoreg(memtoreg_b), .regdst(regdst_b), .link(link_b), .alusrcb(alusrcb_b),
        .pcsrc(pcsrc_b), .aluop(aluop_b), .illegal(illegal_b), .state(state_b), .retired(retired_b)
    );

    always_comb begin
        obs_a = '{st: state_a, mreq: mem_req_a, pcw: pcwrite_a, memw: memwrite_a, irw: irwrite_a,
                  regw: regwrite_a, asa: alusrca_a, br: branch_a, iord: iord_a, m2r: memtoreg_a,
                  rdst: regdst_a, lnk: link_a, ill: illegal_a, asb: alusrcb_a, pcs: pcsrc_a, aop: aluop_a};
        obs_b = '{st: state_b, mreq: mem_req_b, pcw: pcwrite_b, memw: memwrite_b, irw: irwrite_b,
                  regw: regwrite_b, asa: alusrca_b, br: branch_b, iord: iord_b, m2r: memtoreg_b,
                  rdst: regdst_b, lnk: link_b, ill: illegal_b, asb: alusrcb_b, pcs: pcsrc_b, aop: aluop_b};
    end

    // Expected outputs straight from the control-word table of each state.
    function automatic exp_t exp_ctl(input state_t s, input logic rdy);
        exp_t c = '0;
        c.st = s;
        case (s)
            S_FETCH:   begin c.mreq = 1'b1; c.asb = 2'b01; c.pcw = rdy; c.irw = rdy; end
            S_DECODE:  c.asb = 2'b11;
            S_MEMADR,
            S_ADDIEX:  begin c.asa = 1'b1; c.asb = 2'b10; end
            S_MEMRD:   begin c.mreq = 1'b1; c.iord = 1'b1; end
            S_MEMWR:   begin c.mreq = 1'b1; c.iord = 1'b1; c.memw = 1'b1; end
            S_MEMWB:   begin c.regw = 1'b1; c.m2r = 1'b1; end
            S_EXECUTE: begin c.asa = 1'b1; c.aop = 2'b10; end
            S_ALUWB:   begin c.regw = 1'b1; c.rdst = 1'b1; end
            S_ADDIWB:  c.regw = 1'b1;
            S_BRANCH:  begin c.asa = 1'b1; c.br = 1'b1; c.pcs = 2'b01; c.aop = 2'b01; end
            S_JAL:     begin c.regw = 1'b1; c.lnk = 1'b1; c.pcw = 1'b1; c.pcs = 2'b10; end
            S_TRAP:    begin c.ill = 1'b1; c.pcw = 1'b1; c.pcs = 2'b11; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // Runs one instruction on instance a (sel=0) or b (sel=1), checking every cycle.
    task automatic run_instr(input bit sel, input logic [3:0] opc, input int wf, input int wm,
                             input string tag);
        step_t plan[$];
        bit    counts;
        logic  rdy;
        logic [3:0] opd;
        exp_t  e, o;
        for (int i = 0; i < wf; i++) plan.push_back('{S_FETCH, 1'b0});
        plan.push_back('{S_FETCH, 1'b1});
        plan.push_back('{S_DECODE, 1'b0});
        counts = 1'b1;
        if (opc == OPC_ADD || opc == OPC_NAND) begin
            plan.push_back('{S_EXECUTE, 1'b0}); plan.push_back('{S_ALUWB, 1'b0});
        end else if (opc == OPC_LW) begin
            plan.push_back('{S_MEMADR, 1'b0});
            for (int i = 0; i < wm; i++) plan.push_back('{S_MEMRD, 1'b0});
            plan.push_back('{S_MEMRD, 1'b1}); plan.push_back('{S_MEMWB, 1'b0});
        end else if (opc == OPC_SW) begin
            plan.push_back('{S_MEMADR, 1'b0});
            for (int i = 0; i < wm; i++) plan.push_back('{S_MEMWR, 1'b0});
            plan.push_back('{S_MEMWR, 1'b1});
        end else if (opc == OPC_BEQ) begin
            plan.push_back('{S_BRANCH, 1'b0});
        end else if (opc == OPC_JAL) begin
            plan.push_back('{S_JAL, 1'b0});
        end else if (opc == OPC_ADDI) begin
            plan.push_back('{S_ADDIEX, 1'b0}); plan.push_back('{S_ADDIWB, 1'b0});
        end else begin
            counts = 1'b0;
            if (!sel) plan.push_back('{S_TRAP, 1'b0});
        end

        foreach (plan[k]) begin
            // op only matters in DECODE/MEMADR; ready only in FETCH/MEMRD/MEMWR.
            opd = (plan[k].s == S_DECODE || plan[k].s == S_MEMADR) ? opc : 4'($urandom);
            rdy = (plan[k].s == S_FETCH || plan[k].s == S_MEMRD || plan[k].s == S_MEMWR)
                  ? plan[k].rdy : 1'($urandom);
            if (!sel) begin op_a = opd; rdy_a = rdy; op_b = 4'($urandom); rdy_b = 1'b0; end
            else      begin op_b = opd; rdy_b = rdy; op_a = 4'($urandom); rdy_a = 1'b0; end
            @(negedge clk);
            e = exp_ctl(plan[k].s, rdy);
            o = sel ? obs_b : obs_a;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cyc%0d %s: got st=%0d ctl=%h, want st=%0d ctl=%h",
                         tag, k, plan[k].s.name(), o.st, o[17:0], e.st, e[17:0]);
            end
            n_vec++;
            if (!sel && retired_a !== cnt_a) begin
                n_err++;
                $display("FAIL %s retired_a cyc%0d: got %0d want %0d", tag, k, retired_a, cnt_a);
            end else if (sel && retired_b !== cnt_b) begin
                n_err++;
                $display("FAIL %s retired_b cyc%0d: got %0d want %0d", tag, k, retired_b, cnt_b);
            end
            @(posedge clk); #1;
        end
        if (counts) begin
            if (sel) cnt_b = cnt_b + 4'd1;
            else     cnt_a = cnt_a + 32'd1;
        end
    endtask

    task automatic check_retired(input string tag, input logic [31:0] want_a, input logic [3:0] want_b);
        rdy_a = 1'b0; rdy_b = 1'b0;
        @(negedge clk);
        n_vec++;
        if (retired_a !== want_a || retired_b !== want_b) begin
            n_err++;
            $display("FAIL %s: got a=%0d b=%0d want a=%0d b=%0d", tag, retired_a, retired_b, want_a, want_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op_a = 4'b0000; op_b = 4'b0000; rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (obs_a !== exp_ctl(S_FETCH, 1'b0) || obs_b !== exp_ctl(S_FETCH, 1'b0)
            || retired_a !== 32'd0 || retired_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset: got a=%h/%0d b=%h/%0d want %h/0",
                     obs_a, retired_a, obs_b, retired_b, exp_ctl(S_FETCH, 1'b0));
        end
        @(posedge clk); #1;
        reset = 1'b1;
        cnt_a = '0; cnt_b = '0;
    endtask

    task automatic test_add();
        run_instr(1'b0, OPC_ADD, 0, 0, "add");
        check_retired("add_retired", 32'd1, 4'd0);
    endtask

    task automatic test_lw_wait();
        run_instr(1'b0, OPC_LW, 0, 3, "lw_wait");
        check_retired("lw_retired", 32'd2, 4'd0);
    endtask

    task automatic test_fetch_wait();
        run_instr(1'b0, OPC_ADDI, 2, 0, "fetch_wait");
        run_instr(1'b0, OPC_SW, 1, 2, "sw_wait");
    endtask

    task automatic test_trap();
        run_instr(1'b0, 4'b0101, 0, 0, "trap_en");
        run_instr(1'b1, 4'b0101, 1, 0, "trap_silent");
        check_retired("trap_retired", 32'd4, 4'd0);
    endtask

    task automatic test_jal_wrap();
        for (int i = 0; i < 15; i++)
            run_instr(1'b1, (i % 2 == 0) ? OPC_JAL : OPC_BEQ, int'($urandom_range(0, 1)), 0, "jal_fill");
        check_retired("wrap_15", 32'd4, 4'd15);
        run_instr(1'b1, OPC_JAL, 0, 0, "jal_wrap");
        check_retired("wrap_0", 32'd4, 4'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++)
            run_instr(1'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        run_instr(1'b0, OPC_ADD, 0, 0, "pre_reset");
        op_a = OPC_SW; rdy_a = 1'b1; rdy_b = 1'b0;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (obs_a !== exp_ctl(S_MEMWR, 1'b0)) begin
            n_err++;
            $display("FAIL reset_mid_wait: got %h want %h", obs_a, exp_ctl(S_MEMWR, 1'b0));
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        e = exp_ctl(S_FETCH, 1'b0);
        n_vec++;
        if (obs_a !== e || retired_a !== 32'd0 || retired_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_after: got %h/%0d/%0d want %h/0/0", obs_a, retired_a, retired_b, e);
        end
        @(posedge clk); #1;
        cnt_a = '0; cnt_b = '0;
        run_instr(1'b0, OPC_NAND, 0, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_fetch_wait();
        test_trap();
        test_jal_wrap();
        test_random();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
